data_matrix_alu_mc: RTL

Parametrised, multi-cycle successor to the LC-3 datapath ALU.
- Operand width and immediate width are parameters; opcode space widened to 8 ops.
- Adds an iterative shift-add multiply plus registered result, condition-code and overflow outputs.
- Sits on the datapath bus: a start/busy/done handshake to the control FSM, and drives the shared bus through a tri-state gated by gate_alu_en.

---
 rtl/data_matrix_alu_mc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/data_matrix_alu_mc.sv
// data_matrix_alu_mc
//   Multi-cycle datapath ALU. Eight opcodes; all except MUL complete on the
//   accepting edge. MUL is an iterative shift-add that consumes one multiplier
//   bit per cycle. result, nzp and ovf are registered and only change on a
//   commit. alu drives the shared bus with result when gate_alu_en is high.
//
// Handshake: start is sampled only in IDLE. Any start seen while busy is
//   dropped, not queued. done pulses for exactly one cycle, and in that same
//   cycle result/nzp/ovf show the new values. busy is high from the cycle
//   after accept through the done cycle.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         operation request (sampled in IDLE)
//   aluk          opcode
//   ir_slice      [IMM_W]=immediate select, [IMM_W-1:0]=signed immediate
//   sr1, sr2      operand A, operand B register value
//   gate_alu_en   bus drive enable
//   busy, done    status / one-cycle completion pulse
//   result        registered result
//   alu           tri-state bus drive of result
//   nzp, ovf      registered condition codes and overflow flag

module data_matrix_alu_mc #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 5,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       aluk,
    input  logic [IMM_W:0]   ir_slice,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic             gate_alu_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output wire  [WIDTH-1:0] alu,
    output logic [2:0]       nzp,
    output logic             ovf
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_SRA   = 3'b111;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Multiplier working registers. The multiplicand is kept at 2*WIDTH bits
    // so it can be shifted left in place instead of indexing by count.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     count;

    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   comb_res;
    logic               comb_ovf;
    logic [2*WIDTH-1:0] acc_next;

    logic               accept;
    logic               load_mul;
    logic               commit;
    logic [WIDTH-1:0]   commit_res;
    logic               commit_ovf;
    logic [2:0]         commit_nzp;

    // Operand B and the single-cycle result, taken from live inputs. These
    // are only consumed on the accepting edge.
    always_comb begin
        opb      = ir_slice[IMM_W] ?
                   {{(WIDTH-IMM_W){ir_slice[IMM_W-1]}}, ir_slice[IMM_W-1:0]} : sr2;
        sum      = sr1 + opb;
        comb_res = '0;
        comb_ovf = 1'b0;
        case (aluk)
            OP_ADD: begin
                comb_res = sum;
                comb_ovf = (sr1[WIDTH-1] == opb[WIDTH-1]) &&
                           (sum[WIDTH-1] != sr1[WIDTH-1]);
            end
            OP_AND:   comb_res = sr1 & opb;
            OP_NOT:   comb_res = ~sr1;
            OP_PASSA: comb_res = sr1;
            OP_XOR:   comb_res = sr1 ^ opb;
            OP_OR:    comb_res = sr1 | opb;
            OP_SRA:   comb_res = $unsigned($signed(sr1) >>> opb[SHW-1:0]);
            default:  comb_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Next state, handshake outputs and commit selection.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_mul   = 1'b0;
        commit     = 1'b0;
        commit_res = comb_res;
        commit_ovf = comb_ovf;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (aluk == OP_MUL) begin
                        load_mul   = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        commit     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (count == LAST_ITER) begin
                    commit     = 1'b1;
                    commit_res = acc_next[WIDTH-1:0];
                    commit_ovf = |acc_next[2*WIDTH-1:WIDTH];
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        commit_nzp = {commit_res[WIDTH-1],
                      (commit_res == '0),
                      !commit_res[WIDTH-1] && (commit_res != '0)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            nzp    <= 3'b010;
            ovf    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (load_mul) begin
                mcand  <= {{WIDTH{1'b0}}, sr1};
                mplier <= opb;
                acc    <= '0;
                count  <= '0;
            end else if (state == ST_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + SHW'(1);
            end
            if (commit) begin
                result <= commit_res;
                ovf    <= commit_ovf;
                nzp    <= commit_nzp;
            end
        end
    end

    // accept is kept as a named strobe for checkers; it has no other load.
    logic unused_accept;
    assign unused_accept = accept;

    assign alu = gate_alu_en ? result : {WIDTH{1'bz}};

endmodule
